// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Bits needed to hold values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host/pin-side bundle for seg_scan_ctrl: nibble word load handshake and display pins.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IDX_W = seg_pkg::clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] Data;
    logic                    Load;
    logic                    Ack;
    logic [NUM_DIGITS-1:0]   DIG_EN;
    logic [0:6]              SEG;
    logic [IDX_W-1:0]        IDX;

    modport master (output Data, Load, input Ack, DIG_EN, SEG, IDX);
    modport slave  (input Data, Load, output Ack, DIG_EN, SEG, IDX);
endinterface

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low a..g decoder, full 0-F range.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] seg_c
);
    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = 7'b0000001;
            4'h1: seg_c = 7'b1001111;
            4'h2: seg_c = 7'b0010010;
            4'h3: seg_c = 7'b0000110;
            4'h4: seg_c = 7'b1001100;
            4'h5: seg_c = 7'b0100100;
            4'h6: seg_c = 7'b0100000;
            4'h7: seg_c = 7'b0001111;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0000100;
            4'hA: seg_c = 7'b0001000;
            4'hB: seg_c = 7'b1100000;
            4'hC: seg_c = 7'b0110001;
            4'hD: seg_c = 7'b1000010;
            4'hE: seg_c = 7'b0110000;
            4'hF: seg_c = 7'b0111000;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous double buffering.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned GUARD      = 500
) (
    input  logic           Clock,
    input  logic           Resetn,
    seg_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W  = clog2(NUM_DIGITS);
    localparam int unsigned CNT_W  = clog2(PRESCALE);
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [DATA_W-1:0]   active, active_n;
    logic [DATA_W-1:0]   shadow, shadow_n;
    logic                pending, pending_n;
    logic                commit;
    logic [NUM_DIGITS-1:0] dig_en_n;
    logic [0:6]          seg_n;
    logic [3:0]          nibble;
    logic [0:6]          dec_seg;
    logic                lzb;

    // Select the nibble of the word being displayed in the current slot.
    always_comb begin
        nibble = active[3:0];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) nibble = active[4*k +: 4];
        end
    end

    hex7seg u_dec (
        .nibble (nibble),
        .seg_c  (dec_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    // Blank digit k>0 when it and all higher nibbles are zero.
    always_comb begin : lzb_blk
        logic acc;
        acc = 1'b1;
        lzb = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            acc = acc && (active[4*k +: 4] == 4'h0);
            if (idx == IDX_W'(k)) lzb = acc;
        end
    end
`else
    assign lzb = 1'b0;
`endif

    // Slot sequencing, frame commit, shadow load and next-output computation.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        idx_n     = idx;
        active_n  = active;
        shadow_n  = shadow;
        pending_n = pending;
        commit    = 1'b0;
        dig_en_n  = '1;
        seg_n     = SEG_BLANK;

        case (state)
            S_GUARD: begin
                if (cnt == CNT_W'(GUARD - 1)) state_n = S_SHOW;
            end
            S_SHOW: begin
                if (cnt == CNT_W'(PRESCALE - 1)) begin
                    cnt_n   = '0;
                    state_n = S_GUARD;
                    idx_n   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                    if (idx == LAST_IDX && pending) begin
                        commit    = 1'b1;
                        active_n  = shadow;
                        pending_n = 1'b0;
                    end
                end
            end
        endcase

        // A load on the commit edge lands after the commit has taken the old shadow.
        if (bus.Load) begin
            shadow_n  = bus.Data;
            pending_n = 1'b1;
        end

        // idx is unchanged whenever the next state is S_SHOW, so the decoder input is valid.
        if (state_n == S_SHOW) begin
            dig_en_n[idx_n] = 1'b0;
            seg_n           = lzb ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_GUARD;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            bus.Ack    <= 1'b0;
            bus.DIG_EN <= '1;
            bus.SEG    <= SEG_BLANK;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            active     <= active_n;
            shadow     <= shadow_n;
            pending    <= pending_n;
            bus.Ack    <= commit;
            bus.DIG_EN <= dig_en_n;
            bus.SEG    <= seg_n;
        end
    end

    assign bus.IDX = idx;

endmodule
